// File: rtl/prio_encoder_rr.sv
// -----------------------------------------------------------------------------
// prio_encoder_rr
//   Registered N-input priority encoder with enable cascade (ein/eout/gs),
//   a runtime-selectable fixed-priority or round-robin search order, and a
//   single output register guarded by a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ein        in   cascade enable input
//   req        in   [N-1:0] request vector, bit i = source i
//   mode       in   0 = highest index wins, 1 = round-robin
//   out_ready  in   downstream accepts the current result
//   y          out  [W-1:0] encoded index of the granted request
//   grant      out  [N-1:0] one-hot grant, zero when nothing granted
//   gs         out  group select, a request was granted
//   eout       out  cascade enable output, enabled but no request
//   out_valid  out  y/grant hold a result awaiting acceptance
// -----------------------------------------------------------------------------
module prio_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ein,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [N-1:0] grant,
    output logic         gs,
    output logic         eout,
    output logic         out_valid
);

    localparam logic [W-1:0] LastIdx = W'(N - 1);

    logic [W-1:0] y_q, y_d;
    logic [N-1:0] grant_q, grant_d;
    logic         gs_q, gs_d;
    logic         eout_q, eout_d;
    logic         outValid_q, outValid_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         load;
    logic         accept;
    logic [W-1:0] base;
    logic [W-1:0] selIdx;
    logic [W-1:0] candIdx;
    logic         found;
    int           cand;

    // Search base: a same-edge accept moves the base just below the index
    // that was taken, so that source drops to lowest priority immediately.
    // Fixed-priority mode is simply a search starting from the top index,
    // which also parks the pointer there.
    always_comb begin
        load   = !outValid_q | out_ready;
        accept = outValid_q & out_ready;

        if (!mode) begin
            base = LastIdx;
        end else if (accept) begin
            base = (y_q == '0) ? LastIdx : (y_q - W'(1));
        end else begin
            base = ptr_q;
        end

        // Walk downward from base with modulo-N wrap; first set bit wins.
        found   = 1'b0;
        selIdx  = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(base) - k;
            if (cand < 0) begin
                cand = cand + N;
            end
            candIdx = W'(cand);
            if (!found && req[candIdx]) begin
                found  = 1'b1;
                selIdx = candIdx;
            end
        end
    end

    // Next-state values for a sampling edge.
    always_comb begin
        y_d        = '0;
        grant_d    = '0;
        gs_d       = 1'b0;
        eout_d     = 1'b0;
        outValid_d = 1'b0;
        ptr_d      = base;
        if (ein) begin
            if (found) begin
                y_d            = selIdx;
                grant_d[selIdx] = 1'b1;
                gs_d           = 1'b1;
                outValid_d     = 1'b1;
            end else begin
                eout_d = 1'b1;
            end
        end
    end

    // Output register and pointer only move on sampling edges; during a
    // stall everything holds, so a held result is never re-encoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q        <= '0;
            grant_q    <= '0;
            gs_q       <= 1'b0;
            eout_q     <= 1'b0;
            outValid_q <= 1'b0;
            ptr_q      <= LastIdx;
        end else if (load) begin
            y_q        <= y_d;
            grant_q    <= grant_d;
            gs_q       <= gs_d;
            eout_q     <= eout_d;
            outValid_q <= outValid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign y         = y_q;
    assign grant     = grant_q;
    assign gs        = gs_q;
    assign eout      = eout_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// -----------------------------------------------------------------------------
// tb_prio_encoder_rr
//   Directed, table-driven bench for prio_encoder_rr with N=8. Each table row
//   is applied for one clock and the registered outputs are compared just
//   after the edge. Reset and stall behaviour use hand-written sequences.
// -----------------------------------------------------------------------------
module tb_prio_encoder_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         ein;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic [W-1:0] y;
    logic [N-1:0] grant;
    logic         gs;
    logic         eout;
    logic         out_valid;

    int passCount;
    int totalCount;

    typedef struct {
        logic         ein;
        logic [N-1:0] req;
        logic         mode;
        logic         rdy;
        logic [W-1:0] y;
        logic [N-1:0] grant;
        logic         gs;
        logic         eout;
        logic         valid;
    } vec_t;

    vec_t vecs[$];

    prio_encoder_rr #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ein       (ein),
        .req       (req),
        .mode      (mode),
        .out_ready (out_ready),
        .y         (y),
        .grant     (grant),
        .gs        (gs),
        .eout      (eout),
        .out_valid (out_valid)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the inputs for the coming edge.
    task automatic applyStimulus(input logic e, input logic [N-1:0] r,
                                 input logic m, input logic rdy);
        ein       = e;
        req       = r;
        mode      = m;
        out_ready = rdy;
    endtask

    // Compare every output against expected values; one count per field.
    task automatic checkOutput(input string name, input logic [W-1:0] ey,
                               input logic [N-1:0] eg, input logic egs,
                               input logic eeo, input logic ev);
        totalCount += 5;
        if (y === ey) passCount++;
        else $display("[TB] FAIL %s y: got %0d expected %0d", name, y, ey);
        if (grant === eg) passCount++;
        else $display("[TB] FAIL %s grant: got %h expected %h", name, grant, eg);
        if (gs === egs) passCount++;
        else $display("[TB] FAIL %s gs: got %b expected %b", name, gs, egs);
        if (eout === eeo) passCount++;
        else $display("[TB] FAIL %s eout: got %b expected %b", name, eout, eeo);
        if (out_valid === ev) passCount++;
        else $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, ev);
    endtask

    task automatic addVec(input logic e, input logic [N-1:0] r, input logic m,
                          input logic rdy, input logic [W-1:0] ey,
                          input logic [N-1:0] eg, input logic egs,
                          input logic eeo, input logic ev);
        vec_t v;
        v.ein = e; v.req = r; v.mode = m; v.rdy = rdy;
        v.y = ey; v.grant = eg; v.gs = egs; v.eout = eeo; v.valid = ev;
        vecs.push_back(v);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Fixed priority, then cascade/empty cases.
        addVec(1, 8'b0010_0110, 0, 1, 3'd5, 8'h20, 1, 0, 1);
        addVec(1, 8'h00,        0, 1, 3'd0, 8'h00, 0, 1, 0);
        addVec(0, 8'hFF,        0, 1, 3'd0, 8'h00, 0, 0, 0);
        // Round-robin under full load: 7 down to 0 then wrap to 7.
        addVec(1, 8'hFF, 1, 1, 3'd7, 8'h80, 1, 0, 1);
        addVec(1, 8'hFF, 1, 1, 3'd6, 8'h40, 1, 0, 1);
        addVec(1, 8'hFF, 1, 1, 3'd5, 8'h20, 1, 0, 1);
        addVec(1, 8'hFF, 1, 1, 3'd4, 8'h10, 1, 0, 1);
        addVec(1, 8'hFF, 1, 1, 3'd3, 8'h08, 1, 0, 1);
        addVec(1, 8'hFF, 1, 1, 3'd2, 8'h04, 1, 0, 1);
        addVec(1, 8'hFF, 1, 1, 3'd1, 8'h02, 1, 0, 1);
        addVec(1, 8'hFF, 1, 1, 3'd0, 8'h01, 1, 0, 1);
        addVec(1, 8'hFF, 1, 1, 3'd7, 8'h80, 1, 0, 1);
        // Round-robin sparse with wrap, then back to fixed priority.
        addVec(1, 8'h11, 1, 1, 3'd4, 8'h10, 1, 0, 1);
        addVec(1, 8'h11, 1, 1, 3'd0, 8'h01, 1, 0, 1);
        addVec(1, 8'h11, 1, 1, 3'd4, 8'h10, 1, 0, 1);
        addVec(1, 8'h11, 1, 1, 3'd0, 8'h01, 1, 0, 1);
        addVec(1, 8'h11, 0, 1, 3'd4, 8'h10, 1, 0, 1);
        addVec(1, 8'h11, 0, 1, 3'd4, 8'h10, 1, 0, 1);
        addVec(1, 8'h11, 0, 1, 3'd4, 8'h10, 1, 0, 1);

        // Reset state, held across an edge.
        stepCycle();
        checkOutput("reset", 3'd0, 8'h00, 0, 0, 0);
        #3;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ein, vecs[i].req, vecs[i].mode, vecs[i].rdy);
            stepCycle();
            checkOutput($sformatf("vec%0d", i), vecs[i].y, vecs[i].grant,
                        vecs[i].gs, vecs[i].eout, vecs[i].valid);
        end

        // Stall: result 5 held while req/mode change, then released.
        applyStimulus(1'b1, 8'b0010_0110, 1'b0, 1'b1);
        stepCycle();
        checkOutput("stall_load", 3'd5, 8'h20, 1, 0, 1);
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput($sformatf("stall_hold%0d", c), 3'd5, 8'h20, 1, 0, 1);
        end
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
        stepCycle();
        checkOutput("stall_release", 3'd0, 8'h01, 1, 0, 1);

        // Bring ptr to 1 by accepting y=2 in round-robin mode, then reset
        // mid-cycle; outputs clear at once and ptr returns to 7.
        applyStimulus(1'b1, 8'h04, 1'b1, 1'b1);
        stepCycle();
        checkOutput("rr_y2_first", 3'd2, 8'h04, 1, 0, 1);
        stepCycle();
        checkOutput("rr_y2_again", 3'd2, 8'h04, 1, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 3'd0, 8'h00, 0, 0, 0);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
        #1;
        rst_n = 1'b1;
        stepCycle();
        checkOutput("after_reset_rr", 3'd7, 8'h80, 1, 0, 1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-input priority encoder. Next generation of the team's 4-to-2 enable-cascaded encoder.
- Keeps the ein/eout/gs cascade semantics.
- Adds:
  - generic width N;
  - a runtime-selectable round-robin mode;
  - a one-cycle output register with a valid/ready handshake, so it can sit between a request bank and a downstream consumer (arbiter front-end, interrupt controller).

Parameters:
- N, 8, number of request inputs; legal range N >= 2, power of two not required.
- W, $clog2(N), width of the encoded index output. Derived; do not override.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ein  in  1  cascade enable input.
- req  in  N  request vector; bit i = request from source i.
- mode  in  1  0 = fixed priority (highest index wins); 1 = round-robin.
- out_ready  in  1  downstream accepts the current result.
- y  out  W  encoded index of the granted request.
- grant  out  N  one-hot copy of the granted request; all zeros when none.
- gs  out  1  group select: a request was granted (ein=1, req!=0).
- eout  out  1  cascade enable output: ein=1 and req==0.
- out_valid  out  1  y/grant hold a valid result awaiting acceptance.

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle including mid-stall):
  - y=0, grant=0, gs=0, eout=0, out_valid=0.
  - Internal pointer ptr=N-1.
  - Release is synchronous to clk; first sample on the first rising edge with rst_n=1.
- load = !out_valid | out_ready. Sampling occurs only on edges where load=1; otherwise all output registers and ptr hold.
- Latency: result appears exactly 1 cycle after the sampling edge.
- On a sampling edge:
  - ein=1, req!=0: out_valid=1, gs=1, eout=0, y=selected index, grant=1<<y.
  - ein=1, req==0: out_valid=0, gs=0, eout=1, y=0, grant=0.
  - ein=0: out_valid=0, gs=0, eout=0, y=0, grant=0 (req ignored).
- Selection:
  - mode=0: highest set index in req; ptr forced to N-1 on every edge.
  - mode=1: search order is p, p-1, ..., 0, N-1, ..., p+1 (modulo N). The first set bit wins.
- Pointer search base p:
  - p = (accepted index - 1) mod N if a transfer completes on this edge (out_valid & out_ready) and mode=1.
  - Else p = ptr. The same-edge accept and resample uses the updated base, so the same source cannot be granted twice in a row while others request.
- ptr update: on an accepted transfer with mode=1, ptr <= (y - 1) mod N. Wrap: y=0 gives ptr=N-1.
- Mode change takes effect at the next sampling edge. A held result is never re-encoded.
- Stall (out_valid=1, out_ready=0):
  - y/grant/gs/eout/out_valid frozen.
  - req/ein/mode changes are ignored until acceptance.
- gs and out_valid are equal whenever both are registered; both are kept for cascade compatibility.
- Index arithmetic is modulo N, not 2^W (matters for non-power-of-two N).
- No combinational path from inputs to outputs.

Test Plan:
1. Reset: drive N=8, mode=1, accept y=2 (ptr=1), then pulse rst_n=0 mid-cycle -> all outputs 0 immediately (before the next edge). After release, mode=1, req=8'hFF -> y=7.
2. Fixed priority: ein=1, mode=0, req=8'b0010_0110, out_ready=1 -> next cycle y=5, grant=8'h20, gs=1, eout=0, out_valid=1.
3. Cascade/empty:
   - ein=1, req=0 -> eout=1, gs=0, out_valid=0, y=0.
   - ein=0, req=8'hFF -> eout=0, gs=0, out_valid=0.
4. Stall: result y=5 valid, out_ready=0, change req to 8'h01 for 3 cycles -> y stays 5, grant stays 8'h20. Raise out_ready -> next cycle y=0, grant=8'h01.
5. Round-robin full load: mode=1, req=8'hFF, out_ready=1 continuously -> y sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
6. Round-robin sparse with wrap: mode=1, req=8'h11, out_ready=1 -> y alternates 4,0,4,0. Switch to mode=0 -> y=4 every cycle.
